// File: rtl/uart_tx_fifo.sv
// UART transmitter with baud tick generator, runtime frame format (parity, stop bits)
// and a small valid/ready input FIFO.
module uart_tx_fifo #(
   parameter int DBIT    = 8,
   parameter int OS      = 16,
   parameter int DIV_W   = 16,
   parameter int FIFO_AW = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DIV_W-1:0]   baud_div,
   input  logic [1:0]         parity_mode,
   input  logic               two_stop,
   input  logic [DBIT-1:0]    tx_data,
   input  logic               tx_valid,
   output logic               tx_ready,
   output logic               tx,
   output logic               tx_busy,
   output logic               tx_done_tick,
   output logic [FIFO_AW:0]   fifo_count
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int SW    = $clog2(2 * OS);
   localparam int NW    = $clog2(DBIT);
   localparam logic [FIFO_AW:0] FULL    = DEPTH[FIFO_AW:0];
   localparam logic [SW-1:0]    S_LAST  = SW'(OS - 1);
   localparam logic [SW-1:0]    S_LAST2 = SW'(2 * OS - 1);
   localparam logic [NW-1:0]    N_LAST  = NW'(DBIT - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic [DBIT-1:0]    mem [DEPTH];
   logic [FIFO_AW-1:0] wptr, rptr;
   logic               push, pop;

   logic [2:0]         state;
   logic [DIV_W-1:0]   bc;
   logic               s_tick;
   logic [SW-1:0]      s_cnt;
   logic [NW-1:0]      n_cnt;
   logic [DBIT-1:0]    b_reg;
   logic               par_reg;
   logic [1:0]         pmode_reg;
   logic               two_stop_reg;
   logic               par_en;
   logic               par_bit;
   logic               tx_next;

   assign tx_ready = (fifo_count != FULL);
   assign push     = tx_valid & tx_ready;
   assign pop      = (state == IDLE) && (fifo_count != '0);
   assign tx_busy  = (state != IDLE);
   assign s_tick   = (bc == baud_div);
   assign par_en   = (pmode_reg == 2'b01) || (pmode_reg == 2'b10);
   assign par_bit  = (pmode_reg == 2'b10) ? ~par_reg : par_reg;

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= tx_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wptr <= wptr + FIFO_AW'(1);
         if (pop)  rptr <= rptr + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (FIFO_AW + 1)'(1);
            2'b01:   fifo_count <= fifo_count - (FIFO_AW + 1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // tx is registered from the current state, so the line lags the FSM by one clock
   always_comb begin
      tx_next = 1'b1;
      case (state)
         START:   tx_next = 1'b0;
         DATA:    tx_next = b_reg[0];
         PARITY:  tx_next = par_bit;
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         bc           <= '0;
         s_cnt        <= '0;
         n_cnt        <= '0;
         b_reg        <= '0;
         par_reg      <= 1'b0;
         pmode_reg    <= '0;
         two_stop_reg <= 1'b0;
         tx           <= 1'b1;
         tx_done_tick <= 1'b0;
      end else begin
         tx           <= tx_next;
         tx_done_tick <= 1'b0;
         bc           <= s_tick ? '0 : bc + DIV_W'(1);
         case (state)
            IDLE: begin
               // bc restarts here so the start bit gets a full bit period
               if (pop) begin
                  b_reg        <= mem[rptr];
                  par_reg      <= ^mem[rptr];
                  pmode_reg    <= parity_mode;
                  two_stop_reg <= two_stop;
                  s_cnt        <= '0;
                  n_cnt        <= '0;
                  bc           <= '0;
                  state        <= START;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s_cnt == S_LAST) begin
                     s_cnt <= '0;
                     state <= DATA;
                  end else begin
                     s_cnt <= s_cnt + SW'(1);
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s_cnt == S_LAST) begin
                     s_cnt <= '0;
                     b_reg <= b_reg >> 1;
                     if (n_cnt == N_LAST) state <= par_en ? PARITY : STOP;
                     else                 n_cnt <= n_cnt + NW'(1);
                  end else begin
                     s_cnt <= s_cnt + SW'(1);
                  end
               end
            end
            PARITY: begin
               if (s_tick) begin
                  if (s_cnt == S_LAST) begin
                     s_cnt <= '0;
                     state <= STOP;
                  end else begin
                     s_cnt <= s_cnt + SW'(1);
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (s_cnt == (two_stop_reg ? S_LAST2 : S_LAST)) begin
                     s_cnt        <= '0;
                     tx_done_tick <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     s_cnt <= s_cnt + SW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo: reset, 8N1, parity/stop formats, FIFO full,
// mid-frame config change and mid-frame reset.
module tb_uart_tx_fifo;
   logic        clk;
   logic        reset;
   logic [15:0] baud_div;
   logic [1:0]  parity_mode;
   logic        two_stop;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx;
   logic        tx_busy;
   logic        tx_done_tick;
   logic [2:0]  fifo_count;

   int checks = 0;
   int errors = 0;

   logic tx_log   [0:2047];
   logic done_log [0:2047];
   logic busy_log [0:2047];

   uart_tx_fifo #(.DBIT(8), .OS(16), .DIV_W(16), .FIFO_AW(2)) dut (
      .clk(clk), .reset(reset), .baud_div(baud_div), .parity_mode(parity_mode),
      .two_stop(two_stop), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected line levels of one frame, index 0 = start bit; returns bit count.
   function automatic int build_frame(input logic [7:0] d, input logic [1:0] pm,
                                      input logic ts, output logic [15:0] fb);
      int n;
      fb = '1;
      fb[0] = 1'b0;
      for (int i = 0; i < 8; i++) fb[1 + i] = d[i];
      n = 9;
      if (pm == 2'b01) begin fb[n] = ^d; n++; end
      else if (pm == 2'b10) begin fb[n] = ~^d; n++; end
      n += ts ? 2 : 1;
      return n;
   endfunction

   function automatic int count_bad_bits(input logic [15:0] fb, input int n, input int t,
                                         input int offset);
      int bad = 0;
      for (int b = 0; b < n; b++) begin
         for (int c = 0; c < t; c++) begin
            if (tx_log[offset + b * t + c] !== fb[b]) begin bad++; break; end
         end
      end
      return bad;
   endfunction

   function automatic int count_done(input int n);
      int s = 0;
      for (int i = 0; i < n; i++) if (done_log[i] === 1'b1) s++;
      return s;
   endfunction

   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         tx_log[i]   = tx;
         done_log[i] = tx_done_tick;
         busy_log[i] = tx_busy;
      end
   endtask

   task automatic push_word(input logic [7:0] d, output int waited);
      tx_data  = d;
      tx_valid = 1'b1;
      waited   = 0;
      while (tx_ready !== 1'b1 && waited < 1000) begin @(negedge clk); waited++; end
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_fall(output int cnt);
      cnt = 0;
      while (tx !== 1'b0 && cnt < 400) begin @(negedge clk); cnt++; end
   endtask

   task automatic test_reset;
      reset = 1'b1; tx_valid = 1'b0; tx_data = '0;
      baud_div = '0; parity_mode = 2'b00; two_stop = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
      checks++; if (tx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", tx_done_tick); end
      reset = 1'b0;
   endtask

   task automatic test_8n1;
      int w, cnt, n, bad;
      logic [15:0] fb;
      push_word(8'h55, w);
      wait_fall(cnt);
      checks++; if (cnt !== 2) begin errors++; $display("FAIL 8n1_latency: got %0d expected 2", cnt); end
      capture(160);
      n = build_frame(8'h55, 2'b00, 1'b0, fb);
      bad = count_bad_bits(fb, n, 16, 0);
      checks++; if (bad !== 0) begin errors++; $display("FAIL 8n1_bits: bad bits %0d expected 0", bad); end
      checks++; if (busy_log[0] !== 1'b1) begin errors++; $display("FAIL 8n1_busy_start: got %b expected 1", busy_log[0]); end
      checks++; if (done_log[159] !== 1'b1) begin errors++; $display("FAIL 8n1_done_pos: got %b expected 1", done_log[159]); end
      checks++; if (count_done(160) !== 1) begin errors++; $display("FAIL 8n1_done_cnt: got %0d expected 1", count_done(160)); end
      checks++; if (busy_log[159] !== 1'b0 || busy_log[158] !== 1'b1) begin
         errors++; $display("FAIL 8n1_busy_end: got %b%b expected 10", busy_log[158], busy_log[159]);
      end
      @(negedge clk);
      checks++; if (tx_done_tick !== 1'b0) begin errors++; $display("FAIL 8n1_done_width: got %b expected 0", tx_done_tick); end
   endtask

   task automatic test_parity;
      logic [1:0] pm_t  [3] = '{2'b01, 2'b10, 2'b01};
      logic       ts_t  [3] = '{1'b0, 1'b0, 1'b1};
      logic       par_t [3] = '{1'b1, 1'b0, 1'b1};
      int         len_t [3] = '{704, 704, 768};
      int w, cnt, n, bad;
      logic [15:0] fb;
      baud_div = 16'd3;
      for (int k = 0; k < 3; k++) begin
         parity_mode = pm_t[k];
         two_stop    = ts_t[k];
         push_word(8'h07, w);
         wait_fall(cnt);
         checks++; if (cnt !== 2) begin errors++; $display("FAIL par%0d_latency: got %0d expected 2", k, cnt); end
         capture(len_t[k]);
         n = build_frame(8'h07, pm_t[k], ts_t[k], fb);
         bad = count_bad_bits(fb, n, 64, 0);
         checks++; if (bad !== 0) begin errors++; $display("FAIL par%0d_bits: bad bits %0d expected 0", k, bad); end
         checks++; if (tx_log[9 * 64 + 32] !== par_t[k]) begin
            errors++; $display("FAIL par%0d_bit: got %b expected %b", k, tx_log[9 * 64 + 32], par_t[k]);
         end
         checks++; if (done_log[len_t[k] - 1] !== 1'b1 || count_done(len_t[k]) !== 1) begin
            errors++; $display("FAIL par%0d_done: got %b/%0d expected 1/1", k, done_log[len_t[k] - 1], count_done(len_t[k]));
         end
      end
      parity_mode = 2'b00;
      two_stop    = 1'b0;
      baud_div    = '0;
      @(negedge clk);
   endtask

   task automatic test_fifo_full;
      int w6, n, bad, gap_bad;
      logic [15:0] fb;
      baud_div = '0; parity_mode = 2'b00; two_stop = 1'b0;
      w6 = -1;
      fork
         begin
            int w;
            for (int i = 0; i < 6; i++) begin
               if (i == 5) begin
                  checks++; if (fifo_count !== 3'd4 || tx_ready !== 1'b0) begin
                     errors++; $display("FAIL fifo_full: got count %0d ready %b expected 4 0", fifo_count, tx_ready);
                  end
               end
               push_word(8'hA1 + 8'(i), w);
               if (i == 5) w6 = w;
            end
         end
         begin
            int cnt;
            wait_fall(cnt);
            capture(966);
         end
      join
      checks++; if (w6 !== 158) begin errors++; $display("FAIL fifo_held_wait: got %0d expected 158", w6); end
      gap_bad = 0;
      bad = 0;
      for (int j = 0; j < 6; j++) begin
         n = build_frame(8'hA1 + 8'(j), 2'b00, 1'b0, fb);
         bad += count_bad_bits(fb, n, 16, j * 161);
         if (tx_log[j * 161 + 160] !== 1'b1 || done_log[j * 161 + 159] !== 1'b1) gap_bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL fifo_frames: bad bits %0d expected 0", bad); end
      checks++; if (gap_bad !== 0) begin errors++; $display("FAIL fifo_gap_done: bad frames %0d expected 0", gap_bad); end
      checks++; if (count_done(966) !== 6) begin errors++; $display("FAIL fifo_done_cnt: got %0d expected 6", count_done(966)); end
   endtask

   task automatic test_cfg_change;
      int w, n, bad;
      logic [15:0] fb;
      parity_mode = 2'b00;
      push_word(8'h3C, w);
      push_word(8'h83, w);
      fork
         begin
            int cnt;
            wait_fall(cnt);
            capture(340);
         end
         begin
            repeat (60) @(negedge clk);
            parity_mode = 2'b01;
         end
      join
      n = build_frame(8'h3C, 2'b00, 1'b0, fb);
      bad = count_bad_bits(fb, n, 16, 0);
      n = build_frame(8'h83, 2'b01, 1'b0, fb);
      bad += count_bad_bits(fb, n, 16, 161);
      checks++; if (bad !== 0) begin errors++; $display("FAIL cfg_bits: bad bits %0d expected 0", bad); end
      checks++; if (done_log[159] !== 1'b1 || done_log[336] !== 1'b1 || count_done(340) !== 2) begin
         errors++; $display("FAIL cfg_done: got %b %b %0d expected 1 1 2", done_log[159], done_log[336], count_done(340));
      end
      checks++; if (tx_log[161 + 9 * 16 + 8] !== 1'b1) begin
         errors++; $display("FAIL cfg_parity_bit: got %b expected 1", tx_log[161 + 9 * 16 + 8]);
      end
      parity_mode = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int w, cnt, highs;
      parity_mode = 2'b00;
      push_word(8'h0F, w);
      push_word(8'hF0, w);
      wait_fall(cnt);
      repeat (55) @(negedge clk);
      checks++; if (fifo_count !== 3'd1 || tx_busy !== 1'b1) begin
         errors++; $display("FAIL rmid_before: got count %0d busy %b expected 1 1", fifo_count, tx_busy);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rmid_tx: got %b expected 1", tx); end
      checks++; if (fifo_count !== 3'd0 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
         errors++; $display("FAIL rmid_state: got count %0d busy %b ready %b expected 0 0 1", fifo_count, tx_busy, tx_ready);
      end
      reset = 1'b0;
      capture(400);
      highs = 0;
      for (int i = 0; i < 400; i++) if (tx_log[i] === 1'b1) highs++;
      checks++; if (highs !== 400) begin errors++; $display("FAIL rmid_idle: got %0d high cycles expected 400", highs); end
      checks++; if (count_done(400) !== 0) begin errors++; $display("FAIL rmid_done: got %0d expected 0", count_done(400)); end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_fifo_full();
      test_cfg_change();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an on-chip baud tick generator, a runtime-selectable frame format and a small input FIFO with a valid/ready write port. It takes the place of the fixed-format transmitter in the serial path. It sits between bus-side producers, which push words without polling `tx_done_tick`, and the `tx` pin. The block supports 5–9 data bits, none/even/odd parity and 1 or 2 stop bits. Bit rate is set at runtime through a clock divisor.

## Interface
- `DBIT`, 8, data bits per frame; legal range 5..9.
- `OS`, 16, baud ticks per bit (oversampling ratio); legal range 4..32.
- `DIV_W`, 16, width of `baud_div`.
- `FIFO_AW`, 2, FIFO address width; depth = 2^FIFO_AW.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `baud_div`  in  DIV_W  tick period minus 1: one baud tick every `baud_div`+1 clocks.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- `two_stop`  in  1  1 = two stop bits, 0 = one stop bit.
- `tx_data`  in  DBIT  word to transmit; LSB is sent first.
- `tx_valid`  in  1  write request.
- `tx_ready`  out  1  FIFO not full.
- `tx`  out  1  registered serial line; idles high.
- `tx_busy`  out  1  high while the FSM is not in IDLE.
- `tx_done_tick`  out  1  one-cycle pulse at the end of each frame.
- `fifo_count`  out  FIFO_AW+1  number of words currently held.

## Operation
- **Write handshake:** a word is accepted when `tx_valid & tx_ready` is high on a clock edge. `tx_ready = (fifo_count != 2^FIFO_AW)`. `tx_data` is don't-care when `tx_valid` is low.
- **FIFO:** circular buffer whose read and write pointers wrap modulo depth. A push and a pop in the same cycle leave `fifo_count` unchanged. A pop happens only from a non-empty FIFO.
- **Tick generator:**
  - Counter `bc` counts 0..`baud_div`; `s_tick` is high while `bc == baud_div`, and the counter then returns to 0.
  - `bc` is forced to 0 in the IDLE→START cycle, so every bit lasts exactly OS×(`baud_div`+1) clocks.
  - `baud_div` = 0 gives a tick every clock.
- **FSM states:** IDLE, START, DATA, PARITY, STOP. A tick counter `s_cnt` (0..OS-1) and a bit counter `n_cnt` (0..DBIT-1) drive the transitions.
  - **IDLE** (`tx` = 1): if the FIFO is non-empty, pop the head word into shift register `b_reg`. In the same cycle, latch `parity_mode` and `two_stop` into frame-config registers and compute parity over the popped word. Clear `s_cnt` and `n_cnt`, then go to START.
  - **START** (`tx` = 0): on the tick where `s_cnt == OS-1`, clear `s_cnt` and go to DATA. On other ticks, increment `s_cnt`.
  - **DATA** (`tx = b_reg[0]`): on the tick where `s_cnt == OS-1`:
    - shift `b_reg` right;
    - if `n_cnt == DBIT-1`, go to PARITY when parity is enabled, otherwise to STOP;
    - otherwise increment `n_cnt`.
  - **PARITY** (`tx` = parity bit): even parity sends the XOR of the data bits; odd parity sends its inverse. Leaves after OS ticks.
  - **STOP** (`tx` = 1): lasts OS ticks, or 2×OS ticks when the latched `two_stop` is 1. On the final tick, pulse `tx_done_tick` and go to IDLE.
- **Configuration timing:** changes to `parity_mode`, `two_stop` or `baud_div` during a frame do not affect the frame-config registers. A `baud_div` change does alter the running tick period; software changes it only while `tx_busy` = 0.
- **Reset values:**
  - outputs: `tx` = 1, `tx_busy` = 0, `tx_done_tick` = 0, `fifo_count` = 0, `tx_ready` = 1;
  - internal: FIFO pointers = 0, FSM = IDLE, all counters = 0.
- **Reset mid-frame:** the frame is aborted, `tx` goes high on the next edge, and FIFO contents are discarded.

## Timing
- **Latency:** if the FIFO is empty and the FSM is in IDLE, a word accepted at edge k is popped at edge k+1. `tx` falls at edge k+2.
- **Frame length in bit periods:** 1 + DBIT + P + S, where P ∈ {0,1} is the parity bit and S ∈ {1,2} is the stop-bit count.
- **Frame length in clocks:** (1 + DBIT + P + S) × OS × (`baud_div`+1). For 8N1 with OS = 16 and `baud_div` = 0 this is 160 clocks.
- **`tx_done_tick`:** asserted in the cycle the FSM returns to IDLE. `tx_busy` falls at the same edge.
- **Back-to-back frames:** when the FIFO is non-empty at the return to IDLE, the next pop occurs the following cycle. `tx` therefore stays high exactly one extra clock beyond the final stop bit.
- **Full FIFO:** `tx_ready` goes low in the cycle after the write that fills it. It rises in the cycle after the next pop.

## Test plan
- **Reset state:** assert `reset` for 2 cycles -> `tx` = 1, `tx_ready` = 1, `fifo_count` = 0, `tx_busy` = 0, and no `tx_done_tick`.
- **8N1 frame:** `baud_div` = 0, `parity_mode` = 00, `two_stop` = 0, write 0x55 ->
  - `tx` falls 2 clocks after the write;
  - the line carries 0, 1,0,1,0,1,0,1,0, 1, each bit 16 clocks;
  - `tx_done_tick` pulses once at clock 160 of the frame.
- **Parity and two stop bits:** `baud_div` = 3 ->
  - 0x07 with even parity gives parity bit 1 and 11 bit periods of 64 clocks each;
  - 0x07 with odd parity gives parity bit 0;
  - with `two_stop` = 1 the stop level lasts 128 clocks.
- **FIFO full and back-to-back:** `baud_div` = 0, hold `tx_valid` high for 6 cycles with words 0xA1..0xA6 ->
  - words are accepted until `tx_ready` drops;
  - `fifo_count` peaks at 4, and the held word is accepted after the first pop;
  - all accepted words are sent in order with a 1-clock idle gap between frames;
  - one `tx_done_tick` is produced per frame.
- **Config change mid-frame:** switch `parity_mode` to 01 during the DATA bits of an 8N1 frame -> the current frame has no parity bit, and the next frame carries parity.
- **Reset mid-frame:** write 0x0F then 0xF0, and assert `reset` during the 3rd data bit of the first frame -> `tx` = 1 on the next edge, `fifo_count` = 0, and no further frames or `tx_done_tick` follow.
